// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one word read per fetch_req over a valid/ready
// request and valid-only response channel, then holds the result until acknowledged.
module inst_fetch #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] pc_i,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ack,
  output logic        fetch_err,
  output logic [1:0]  err_cause,
  output logic        busy,
  output logic [31:0] fetch_count
);

  // state | meaning
  // IDLE  | no fetch in progress
  // REQ   | request presented, waiting for imem_req_ready
  // WAIT  | request accepted, waiting for response or timeout
  // HOLD  | instruction (or error NOP) presented until inst_ack
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_MISAL = 2'd1;
  localparam logic [1:0] CAUSE_BUS   = 2'd2;
  localparam logic [1:0] CAUSE_TMO   = 2'd3;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   pc_q, pc_d;
  logic          err_q, err_d;
  logic [1:0]    cause_q, cause_d;
  logic          drop_q, drop_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [31:0]   count_q, count_d;
  logic          launch;
  logic          discard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      inst_q  <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
      drop_q  <= 1'b0;
      tmr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      cause_q <= cause_d;
      drop_q  <= drop_d;
      tmr_q   <= tmr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    err_d   = err_q;
    cause_d = cause_q;
    drop_d  = drop_q;
    tmr_d   = tmr_q;
    count_d = count_q;
    launch  = 1'b0;
    // A flush in the same cycle as the response already cancels it.
    discard = drop_q | flush;

    case (state_q)
      IDLE: begin
        if (!flush && fetch_req) launch = 1'b1;
      end
      REQ: begin
        if (flush) drop_d = 1'b1;
        if (imem_req_ready) begin
          state_d = WAIT;
          tmr_d   = TMR_LOAD;
        end
      end
      WAIT: begin
        if (flush) drop_d = 1'b1;
        if (imem_rsp_valid) begin
          if (discard) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = HOLD;
            if (imem_rsp_err) begin
              inst_d  = NOP_INST;
              err_d   = 1'b1;
              cause_d = CAUSE_BUS;
            end else begin
              inst_d  = imem_rsp_data;
              err_d   = 1'b0;
              cause_d = CAUSE_NONE;
            end
          end
        end else if (tmr_q == '0) begin
          if (discard) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else begin
            state_d = HOLD;
            inst_d  = NOP_INST;
            err_d   = 1'b1;
            cause_d = CAUSE_TMO;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (inst_ack) begin
          count_d = count_q + 32'd1;
          state_d = IDLE;
          if (fetch_req) launch = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      addr_d = pc_i;
      pc_d   = pc_i;
      drop_d = 1'b0;
      if (pc_i[1:0] != 2'b00) begin
        state_d = HOLD;
        inst_d  = NOP_INST;
        err_d   = 1'b1;
        cause_d = CAUSE_MISAL;
      end else begin
        state_d = REQ;
        err_d   = 1'b0;
        cause_d = CAUSE_NONE;
      end
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = addr_q;
  assign inst_o         = inst_q;
  assign inst_pc        = pc_q;
  assign inst_valid     = (state_q == HOLD);
  assign fetch_err      = err_q;
  assign err_cause      = cause_q;
  assign busy           = (state_q != IDLE);
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized fetches
// checked against a transaction-level expectation of each fetch's outcome.
module tb_inst_fetch;
  localparam int T = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] pc_i;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic [31:0] inst_o;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ack;
  logic        fetch_err;
  logic [1:0]  err_cause;
  logic        busy;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  inst_fetch #(.TIMEOUT(T), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_i(pc_i), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst_o(inst_o), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ack(inst_ack),
    .fetch_err(fetch_err), .err_cause(err_cause), .busy(busy), .fetch_count(fetch_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_count = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a fetch in the current cycle; with_ack also acknowledges a held instruction.
  task automatic issue(input logic [31:0] pc, input bit with_ack);
    fetch_req = 1'b1;
    pc_i      = pc;
    inst_ack  = with_ack;
    step();
    fetch_req = 1'b0;
    inst_ack  = 1'b0;
    pc_i      = $urandom;
    if (with_ack) exp_count++;
  endtask

  // Drive the memory side of one fetch and check the held result.
  // rdly: cycles with ready low; rspd: WAIT cycle index of the response (>= T means none).
  task automatic body(input logic [31:0] pc, input int rdly, input int rspd, input bit berr,
                      input logic [31:0] data, input int hold_cyc);
    logic [1:0]  cause;
    logic [31:0] inst;
    bit          tmo;
    tmo = (rspd >= T);
    if (pc[1:0] != 2'b00) cause = 2'd1;
    else if (tmo)         cause = 2'd3;
    else if (berr)        cause = 2'd2;
    else                  cause = 2'd0;
    inst = (cause == 2'd0) ? data : NOP;

    if (pc[1:0] == 2'b00) begin
      for (int i = 0; i <= rdly; i++) begin
        chk("req_valid", imem_req_valid, 1);
        chk("req_addr", imem_req_addr, pc);
        imem_req_ready = (i == rdly);
        imem_rsp_valid = ($urandom_range(0, 3) == 0);
        imem_rsp_data  = $urandom;
        imem_rsp_err   = 1'($urandom_range(0, 1));
        step();
      end
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      for (int k = 0; k < T; k++) begin
        chk("wait_inst_valid", inst_valid, 0);
        chk("wait_req_valid", imem_req_valid, 0);
        if (k == rspd) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = data;
          imem_rsp_err   = berr;
        end
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        if (k == rspd) break;
      end
    end else begin
      chk("misal_no_req", imem_req_valid, 0);
    end

    for (int h = 0; h <= hold_cyc; h++) begin
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", inst_o, inst);
      chk("hold_pc", inst_pc, pc);
      chk("hold_err", fetch_err, cause != 2'd0);
      chk("hold_cause", err_cause, cause);
      chk("hold_busy", busy, 1);
      chk("hold_count", fetch_count, exp_count);
      if (h < hold_cyc) begin
        imem_rsp_valid = tmo;
        imem_rsp_data  = $urandom;
        step();
        imem_rsp_valid = 1'b0;
      end
    end
  endtask

  // Acknowledge, then check a stray response in IDLE does not start anything.
  task automatic ack_idle();
    inst_ack       = 1'b1;
    imem_rsp_valid = 1'($urandom_range(0, 1));
    imem_rsp_data  = $urandom;
    step();
    inst_ack  = 1'b0;
    exp_count++;
    chk("ack_valid", inst_valid, 0);
    chk("ack_busy", busy, 0);
    chk("ack_count", fetch_count, exp_count);
    imem_rsp_valid = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    chk("idle_stays", busy, 0);
  endtask

  initial begin
    logic [31:0] pc;
    bit          in_hold;

    rst = 1'b1; fetch_req = 1'b0; pc_i = '0; flush = 1'b0; inst_ack = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_cause", err_cause, 0);
    rst = 1'b0;
    step();

    // zero-wait fetch
    issue(32'h8000_0000, 0);
    body(32'h8000_0000, 0, 0, 0, 32'h0010_0093, 0);
    ack_idle();
    chk("zero_wait_count", fetch_count, 1);

    // backpressure and slow memory
    issue(32'h8000_0010, 0);
    body(32'h8000_0010, 4, 5, 0, 32'hCAFE_0001, 2);
    ack_idle();

    // misaligned pc
    issue(32'h8000_0002, 0);
    body(32'h8000_0002, 0, 0, 0, 32'h0, 1);
    ack_idle();

    // bus error
    issue(32'h8000_0020, 0);
    body(32'h8000_0020, 1, 2, 1, 32'h1234_5678, 0);
    ack_idle();

    // timeout, late response during hold and after ack
    issue(32'h8000_0030, 0);
    body(32'h8000_0030, 0, T, 0, 32'h0, 2);
    ack_idle();

    // flush in REQ: handshake still completes, response dropped
    issue(32'h0000_1000, 0);
    flush = 1'b1;
    imem_req_ready = 1'b0;
    step();
    flush = 1'b0;
    chk("flreq_valid_kept", imem_req_valid, 1);
    chk("flreq_addr_kept", imem_req_addr, 32'h0000_1000);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk("flreq_busy", busy, 0);
    chk("flreq_inst_valid", inst_valid, 0);
    chk("flreq_count", fetch_count, exp_count);

    // flush in WAIT
    issue(32'h0000_2000, 0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flwait_inst_valid", inst_valid, 0);
    imem_rsp_valid = 1'b1;
    step();
    imem_rsp_valid = 1'b0;
    chk("flwait_busy", busy, 0);
    chk("flwait_inst_valid2", inst_valid, 0);
    chk("flwait_count", fetch_count, exp_count);

    // flush in WAIT with no response: timeout returns to IDLE silently
    issue(32'h0000_2100, 0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (T - 2) step();
    chk("fltmo_busy_last", busy, 1);
    step();
    chk("fltmo_busy", busy, 0);
    chk("fltmo_inst_valid", inst_valid, 0);

    // flush beats ack in HOLD
    issue(32'h0000_3000, 0);
    body(32'h0000_3000, 0, 1, 0, 32'h0000_0ABC, 0);
    flush = 1'b1;
    inst_ack = 1'b1;
    step();
    flush = 1'b0;
    inst_ack = 1'b0;
    chk("flhold_busy", busy, 0);
    chk("flhold_valid", inst_valid, 0);
    chk("flhold_count", fetch_count, exp_count);

    // randomized fetches, optionally back-to-back
    in_hold = 1'b0;
    for (int it = 0; it < 40; it++) begin
      pc = $urandom;
      if ($urandom_range(0, 4) != 0) pc[1:0] = 2'b00;
      if (in_hold && $urandom_range(0, 1) == 1) begin
        issue(pc, 1);
      end else begin
        if (in_hold) ack_idle();
        issue(pc, 0);
      end
      body(pc, $urandom_range(0, 4), $urandom_range(0, T + 2), ($urandom_range(0, 5) == 0),
           $urandom, $urandom_range(0, 3));
      in_hold = 1'b1;
    end
    ack_idle();

    // async reset mid-WAIT, away from the clock edge
    issue(32'h0000_4000, 0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_inst_valid", inst_valid, 0);
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_count", fetch_count, 0);
    chk("arst_inst", inst_o, 0);
    chk("arst_err", fetch_err, 0);
    exp_count = '0;
    step();
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h5555_AAAA;
    step();
    imem_rsp_valid = 1'b0;
    chk("arst_rsp_ignored", busy, 0);
    chk("arst_rsp_no_valid", inst_valid, 0);

    // ten back-to-back fetches at one per three cycles
    issue(32'h8000_1000, 0);
    body(32'h8000_1000, 0, 0, 0, $urandom, 0);
    for (int i = 1; i < 10; i++) begin
      issue(32'h8000_1000 + 32'(4 * i), 1);
      body(32'h8000_1000 + 32'(4 * i), 0, 0, 0, $urandom, 0);
    end
    ack_idle();
    chk("b2b_count", fetch_count, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
